// File: rtl/oam_dma_engine_if.sv
// Bus bundle between the CPU bus decode / top-level mux and the OAM DMA engine.
// master = top-level side, slave = the DMA engine.
interface oam_dma_engine_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw_n;
    logic [7:0]  mem_data_in;

    logic        dma_active;
    logic        cpu_halt;
    logic [15:0] dma_addr;
    logic        dma_rden;
    logic        oam_wren;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        dma_done;

    modport master (
        output cpu_addr,
        output cpu_data_out,
        output cpu_rw_n,
        output mem_data_in,
        input  dma_active,
        input  cpu_halt,
        input  dma_addr,
        input  dma_rden,
        input  oam_wren,
        input  oam_addr,
        input  oam_data,
        input  dma_done
    );

    modport slave (
        input  cpu_addr,
        input  cpu_data_out,
        input  cpu_rw_n,
        input  mem_data_in,
        output dma_active,
        output cpu_halt,
        output dma_addr,
        output dma_rden,
        output oam_wren,
        output oam_addr,
        output oam_data,
        output dma_done
    );
endinterface

// File: rtl/oam_dma_engine.sv
// Sprite OAM DMA: a $4014 write halts the CPU and copies page $XX00-$XXFF
// into OAM with get/put alternation (513 or 514 enabled cycles).
module oam_dma_engine #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    oam_dma_engine_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] page;
    logic [7:0] index;
    logic       put_cycle;
    logic       trigger;
    logic       last_byte;

    assign trigger   = ~bus.cpu_rw_n && (bus.cpu_addr == DMA_REG_ADDR);
    assign last_byte = (index == 8'hFF);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = trigger ? S_HALT : S_IDLE;
            // READ must land on a get cycle, so a get-cycle HALT burns one ALIGN
            S_HALT:  state_nxt = put_cycle ? S_READ : S_ALIGN;
            S_ALIGN: state_nxt = S_READ;
            S_READ:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_byte ? S_IDLE : S_READ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            page      <= 8'h00;
            index     <= 8'h00;
            put_cycle <= 1'b0;
        end else if (ENABLE) begin
            state     <= state_nxt;
            put_cycle <= ~put_cycle;
            if (state == S_IDLE && trigger) begin
                page  <= bus.cpu_data_out;
                index <= 8'h00;
            end
            if (state == S_WRITE) begin
                index <= index + 8'h01;
            end
        end
    end

    assign bus.dma_active = (state != S_IDLE);
    assign bus.cpu_halt   = (state != S_IDLE);
    assign bus.dma_rden   = (state == S_READ);
    assign bus.oam_wren   = (state == S_WRITE);
    assign bus.dma_addr   = (state == S_READ) ? {page, index} : 16'h0000;
    assign bus.oam_addr   = (state == S_WRITE) ? index : 8'h00;
    assign bus.oam_data   = (state == S_WRITE) ? bus.mem_data_in : 8'h00;
    assign bus.dma_done   = (state == S_WRITE) && last_byte;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: trigger vector table, directed transfers and
// randomized transfers checked against a RAM/OAM reference model.
module tb_oam_dma_engine;

    logic CLK = 1'b0;
    logic RESET;
    logic ENABLE;

    oam_dma_engine_if bus();

    oam_dma_engine #(.DMA_REG_ADDR(16'h4014)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int vecs = 0;
    int miscmp = 0;

    logic [7:0] ram [0:65535];
    int unsigned en_edges = 0;

    // Enabled edges since reset; its parity is the get/put phase
    always @(posedge CLK) begin
        if (RESET) en_edges <= 0;
        else if (ENABLE) en_edges <= en_edges + 1;
    end

    // Bus mux: read data valid the enabled cycle after dma_rden, junk otherwise
    always @(posedge CLK) begin
        if (ENABLE)
            bus.mem_data_in <= bus.dma_rden ? ram[bus.dma_addr] : 8'($urandom);
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw_n;
        logic        en;
        logic        rst;
        logic        exp_act;
    } vec_t;

    vec_t tv [6];

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic xfer(input logic [7:0] pg, input bit want_put,
                        input int en_mode, input int inject_at,
                        input int rst_idx);
        int act = 0;
        int wrn = 0;
        int done = 0;
        int first_rd = -1;
        int exp_idx = 0;
        int data_err = 0;
        int order_err = 0;
        int hold_err = 0;
        int exp_len;
        bit par;
        bit started = 0;
        bit finished = 0;
        bit was_reset = 0;
        bit prev_en = 1;
        logic [28:0] snap = '0;
        logic [28:0] cur;

        cyc();
        ENABLE = 1'b1;
        RESET = 1'b0;
        bus.cpu_rw_n = 1'b1;
        bus.cpu_addr = 16'h0000;
        if (bit'((en_edges + 1) & 1) != want_put) cyc();
        bus.cpu_addr = 16'h4014;
        bus.cpu_data_out = pg;
        bus.cpu_rw_n = 1'b0;
        cyc();
        bus.cpu_rw_n = 1'b1;
        bus.cpu_addr = 16'h0000;
        par = en_edges[0];
        exp_len = par ? 513 : 514;

        for (int c = 0; c < 4000 && !finished; c++) begin
            case (en_mode)
                1: ENABLE = (c % 2 == 0);
                2: ENABLE = ($urandom_range(0, 3) != 0);
                default: ENABLE = 1'b1;
            endcase
            if (inject_at >= 0 && act == inject_at) begin
                bus.cpu_addr = 16'h4014;
                bus.cpu_data_out = 8'h07;
                bus.cpu_rw_n = 1'b0;
            end else begin
                bus.cpu_addr = 16'h0000;
                bus.cpu_rw_n = 1'b1;
            end
            if (rst_idx >= 0 && bus.oam_wren && bus.oam_addr == rst_idx) begin
                RESET = 1'b1;
                ENABLE = 1'b1;
            end
            @(negedge CLK);
            cur = {bus.dma_active, bus.cpu_halt, bus.dma_rden, bus.oam_wren,
                   bus.dma_addr, bus.oam_addr, bus.dma_done};
            if (!prev_en && started && cur != snap) hold_err++;
            snap = cur;
            prev_en = ENABLE;
            if (bus.dma_active) started = 1;
            else if (started) finished = 1;
            if (ENABLE && bus.dma_active) begin
                if (bus.dma_rden && first_rd < 0) first_rd = act;
                act++;
            end
            if (ENABLE && bus.oam_wren) begin
                if (bus.oam_addr != exp_idx[7:0]) order_err++;
                if (bus.oam_data != ram[{pg, bus.oam_addr}]) data_err++;
                exp_idx++;
                wrn++;
            end
            if (ENABLE && bus.dma_done) begin
                done++;
                if (bus.oam_addr != 8'hFF) order_err++;
            end
            if (RESET) begin
                cyc();
                RESET = 1'b0;
                @(negedge CLK);
                check("rst_dma_active", int'(bus.dma_active), 0);
                check("rst_cpu_halt", int'(bus.cpu_halt), 0);
                finished = 1;
                was_reset = 1;
            end else if (!finished) begin
                cyc();
            end
        end
        if (!finished) check("xfer_timeout", 1, 0);
        cyc();

        check("write_order", order_err, 0);
        check("oam_data", data_err, 0);
        if (was_reset) begin
            check("rst_write_count", wrn, rst_idx + 1);
        end else begin
            check("active_cycles", act, exp_len);
            check("write_count", wrn, 256);
            check("done_pulses", done, 1);
            check("first_read_at", first_rd, par ? 1 : 2);
            check("hold_when_disabled", hold_err, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;

        tv[0] = '{16'h4014, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[1] = '{16'h4015, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{16'h4013, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{16'h4014, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4] = '{16'h4014, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[5] = '{16'h4014, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1};

        RESET = 1'b1;
        ENABLE = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_data_out = 8'h00;
        bus.cpu_rw_n = 1'b1;
        cyc();
        cyc();
        @(negedge CLK);
        check("reset_dma_active", int'(bus.dma_active), 0);
        check("reset_cpu_halt", int'(bus.cpu_halt), 0);
        check("reset_dma_addr", int'(bus.dma_addr), 0);
        check("reset_dma_rden", int'(bus.dma_rden), 0);
        check("reset_oam_wren", int'(bus.oam_wren), 0);
        check("reset_oam_addr", int'(bus.oam_addr), 0);
        check("reset_oam_data", int'(bus.oam_data), 0);
        check("reset_dma_done", int'(bus.dma_done), 0);
        cyc();
        RESET = 1'b0;
        ENABLE = 1'b1;

        foreach (tv[k]) begin
            RESET = 1'b1;
            cyc();
            RESET = tv[k].rst;
            ENABLE = tv[k].en;
            bus.cpu_addr = tv[k].addr;
            bus.cpu_data_out = tv[k].data;
            bus.cpu_rw_n = tv[k].rw_n;
            cyc();
            RESET = 1'b0;
            ENABLE = 1'b1;
            bus.cpu_addr = 16'h0000;
            bus.cpu_rw_n = 1'b1;
            @(negedge CLK);
            check($sformatf("vec%0d_dma_active", k), int'(bus.dma_active), int'(tv[k].exp_act));
            check($sformatf("vec%0d_cpu_halt", k), int'(bus.cpu_halt), int'(tv[k].exp_act));
            check($sformatf("vec%0d_dma_rden", k), int'(bus.dma_rden), 0);
            cyc();
        end
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;

        xfer(8'h02, 1'b0, 0, -1, -1);
        xfer(8'h02, 1'b1, 0, -1, -1);
        xfer(8'h02, 1'b0, 0, 100, -1);
        xfer(8'h02, 1'b1, 1, -1, -1);
        xfer(8'h02, 1'b0, 1, -1, -1);
        xfer(8'h02, 1'b0, 0, -1, 8'h80);
        xfer(8'h02, 1'b1, 0, -1, -1);
        repeat (6) xfer(8'($urandom), 1'($urandom), 2, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
